// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetches one instruction word per request from the PC's
// next address over an imem req/ack handshake, loads it into the instruction
// register and pulses pcen so the PC commits exactly the fetched address.
// Optional feature macro: IFETCH_TIMEOUT_EN enables the ack timeout / bus_err path.
module instr_fetch_unit #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_start,
    input  logic              flush,
    input  logic [ADDR_W-1:0] pc_addr,
    output logic              pcen,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              imem_ack,
    output logic [DATA_W-1:0] ir,
    output logic              ir_valid,
    output logic              fetch_busy,
    output logic              fetch_done,
    output logic              addr_err,
    output logic              bus_err
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE,
        ERR
    } state_t;

    state_t state;
    state_t state_next;
    logic   flush_pend;
    logic   timeout_hit;
    logic   start_ok;
    logic   start_bad;
    logic   drop_fetch;

    // The 8-bit wait counter cannot represent a limit outside 1..255.
    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_timeout
        $error("instr_fetch_unit: TIMEOUT_CYC must be in 1..255");
    end

    assign start_ok   = (state == IDLE) && fetch_start && !flush && (pc_addr[1:0] == 2'b00);
    assign start_bad  = (state == IDLE) && fetch_start && !flush && (pc_addr[1:0] != 2'b00);
    assign drop_fetch = flush || flush_pend;
    assign fetch_busy = (state != IDLE);

    // State register; reset drops any in-flight request immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs; a flush in DONE suppresses the commit.
    always_comb begin
        state_next = state;
        imem_req   = 1'b0;
        pcen       = 1'b0;
        fetch_done = 1'b0;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    state_next = REQ;
                end else if (start_bad) begin
                    state_next = ERR;
                end
            end
            REQ: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    state_next = drop_fetch ? IDLE : DONE;
                end else if (timeout_hit) begin
                    state_next = ERR;
                end
            end
            DONE: begin
                pcen       = !flush;
                fetch_done = !flush;
                state_next = IDLE;
            end
            ERR: begin
                if (flush) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Address capture, instruction register, pending flush and alignment error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_addr  <= '0;
            ir         <= '0;
            ir_valid   <= 1'b0;
            addr_err   <= 1'b0;
            flush_pend <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        imem_addr  <= pc_addr;
                        ir_valid   <= 1'b0;
                        flush_pend <= 1'b0;
                    end
                    if (start_bad) begin
                        addr_err <= 1'b1;
                    end
                end
                REQ: begin
                    if (flush) begin
                        flush_pend <= 1'b1;
                    end
                    if (imem_ack && !drop_fetch) begin
                        ir <= imem_rdata;
                    end
                end
                DONE: begin
                    if (!flush) begin
                        ir_valid <= 1'b1;
                    end
                end
                ERR: begin
                    if (flush) begin
                        addr_err <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef IFETCH_TIMEOUT_EN
    logic [7:0] wait_cnt;

    assign timeout_hit = (state == REQ) && !imem_ack && (wait_cnt == 8'(TIMEOUT_CYC - 1));

    // Count REQ cycles without ack; an ack in the limit cycle wins over the timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            bus_err  <= 1'b0;
        end else begin
            if (start_ok) begin
                wait_cnt <= '0;
            end else if ((state == REQ) && !imem_ack) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            if (timeout_hit) begin
                bus_err <= 1'b1;
            end else if ((state == ERR) && flush) begin
                bus_err <= 1'b0;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign bus_err     = 1'b0;
`endif

endmodule
